mc_controller: RTL and testbench



---
 rtl/mips_defs.sv | 116 +++++++++++
 rtl/mc_decode.sv | 90 +++++++++
 rtl/mc_controller.sv | 119 +++++++++++
 tb/tb_mc_controller.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_defs.sv
// Shared MIPS control definitions: opcodes, FSM states, datapath select codes.
// Latency: none (constants, types and pure functions only).
// Backpressure: not applicable.
package mips_defs;

  // Opcodes and functs of the supported subset
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  // FSM state encodings
  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;

  // Datapath select codes, shared with the datapath muxes
  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_OR    = 3'b010;
  localparam logic [2:0] ALU_PASSB = 3'b011;

  localparam logic [1:0] EXT_ZERO  = 2'b00;
  localparam logic [1:0] EXT_SIGN  = 2'b01;
  localparam logic [1:0] EXT_LUI   = 2'b10;

  localparam logic [1:0] NPC_PC4   = 2'b00;
  localparam logic [1:0] NPC_BR    = 2'b01;
  localparam logic [1:0] NPC_J     = 2'b10;
  localparam logic [1:0] NPC_JR    = 2'b11;

  localparam logic [1:0] WD_ALU    = 2'b00;
  localparam logic [1:0] WD_DM     = 2'b01;
  localparam logic [1:0] WD_PC4    = 2'b10;

  localparam logic [1:0] DST_RT    = 2'b00;
  localparam logic [1:0] DST_RD    = 2'b01;
  localparam logic [1:0] DST_RA    = 2'b10;

  typedef enum logic [3:0] {
    I_ADDU, I_SUBU, I_ORI, I_LUI, I_LW, I_SW, I_BEQ, I_J, I_JAL, I_JR, I_ILL
  } instr_t;

  // ALU operand/operation settings for one instruction
  typedef struct packed {
    logic       alu_src;
    logic [1:0] ext_op;
    logic [2:0] alu_ctrl;
  } alu_cfg_t;

  // Full control word driven towards the datapath
  typedef struct packed {
    logic       ir_we;
    logic       pc_we;
    logic [1:0] npc_sel;
    logic       reg_we;
    logic [1:0] reg_dst;
    logic [1:0] wd_sel;
    alu_cfg_t   alu;
    logic       mem_req;
    logic       mem_we;
    logic       illegal;
  } ctrl_t;

  // Map opcode/funct onto an instruction class; anything unknown is I_ILL
  function automatic instr_t classify(input logic [5:0] op, input logic [5:0] func);
    instr_t r;
    r = I_ILL;
    case (op)
      OP_RTYPE: begin
        case (func)
          FN_ADDU: r = I_ADDU;
          FN_SUBU: r = I_SUBU;
          FN_JR:   r = I_JR;
          default: r = I_ILL;
        endcase
      end
      OP_ORI:  r = I_ORI;
      OP_LUI:  r = I_LUI;
      OP_LW:   r = I_LW;
      OP_SW:   r = I_SW;
      OP_BEQ:  r = I_BEQ;
      OP_J:    r = I_J;
      OP_JAL:  r = I_JAL;
      default: r = I_ILL;
    endcase
    return r;
  endfunction

  // ALU settings used from EXEC onwards; zero for classes that never use the ALU
  function automatic alu_cfg_t alu_cfg(input instr_t ins);
    alu_cfg_t c;
    c = '0;
    case (ins)
      I_ADDU:      c = '{alu_src: 1'b0, ext_op: EXT_ZERO, alu_ctrl: ALU_ADD};
      I_SUBU:      c = '{alu_src: 1'b0, ext_op: EXT_ZERO, alu_ctrl: ALU_SUB};
      I_ORI:       c = '{alu_src: 1'b1, ext_op: EXT_ZERO, alu_ctrl: ALU_OR};
      I_LUI:       c = '{alu_src: 1'b1, ext_op: EXT_LUI,  alu_ctrl: ALU_PASSB};
      I_LW, I_SW:  c = '{alu_src: 1'b1, ext_op: EXT_SIGN, alu_ctrl: ALU_ADD};
      I_BEQ:       c = '{alu_src: 1'b0, ext_op: EXT_ZERO, alu_ctrl: ALU_SUB};
      default:     c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mc_decode.sv
// Control-word decoder: (state, latched op/func, alu_zero, mem_ready) -> datapath controls.
// Latency: purely combinational, zero cycles.
// Backpressure: mem_ready only gates the sw completion (pc_we) while in MEM.
module mc_decode
  import mips_defs::*;
(
  input  logic [2:0] state,
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic       alu_zero,
  input  logic       mem_ready,
  output ctrl_t      ctrl
);

  instr_t   ins;
  alu_cfg_t cfg;

  assign ins = classify(op, func);
  assign cfg = alu_cfg(ins);

  // Decode the control word for the current state and instruction class
  always_comb begin
    ctrl = '0;
    case (state)
      ST_FETCH: ctrl.ir_we = 1'b1;

      ST_DECODE: begin
        case (ins)
          I_J: begin
            ctrl.pc_we   = 1'b1;
            ctrl.npc_sel = NPC_J;
          end
          I_JAL: begin
            ctrl.pc_we   = 1'b1;
            ctrl.npc_sel = NPC_J;
            ctrl.reg_we  = 1'b1;
            ctrl.reg_dst = DST_RA;
            ctrl.wd_sel  = WD_PC4;
          end
          I_JR: begin
            ctrl.pc_we   = 1'b1;
            ctrl.npc_sel = NPC_JR;
          end
          I_ILL: begin
            ctrl.illegal = 1'b1;
            ctrl.pc_we   = 1'b1;
            ctrl.npc_sel = NPC_PC4;
          end
          default: ;
        endcase
      end

      ST_EXEC: begin
        ctrl.alu = cfg;
        // Branch resolves here from the live zero flag
        if (ins == I_BEQ) begin
          ctrl.pc_we   = 1'b1;
          ctrl.npc_sel = alu_zero ? NPC_BR : NPC_PC4;
        end
      end

      ST_MEM: begin
        if (ins == I_LW || ins == I_SW) begin
          ctrl.alu     = cfg;
          ctrl.mem_req = 1'b1;
          ctrl.mem_we  = (ins == I_SW);
          // A store retires in the cycle the memory accepts it
          if (ins == I_SW && mem_ready) begin
            ctrl.pc_we   = 1'b1;
            ctrl.npc_sel = NPC_PC4;
          end
        end
      end

      ST_WB: begin
        if (ins == I_ADDU || ins == I_SUBU || ins == I_ORI || ins == I_LUI || ins == I_LW) begin
          ctrl.alu     = cfg;
          ctrl.reg_we  = 1'b1;
          ctrl.pc_we   = 1'b1;
          ctrl.npc_sel = NPC_PC4;
          ctrl.reg_dst = (ins == I_ADDU || ins == I_SUBU) ? DST_RD : DST_RT;
          ctrl.wd_sel  = (ins == I_LW) ? WD_DM : WD_ALU;
        end
      end

      default: ;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle MIPS control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing of the datapath.
// Latency: 2 (j/jal/jr/illegal), 3 (beq), 4 (alu/sw), 5 (lw) cycles plus memory wait.
// Backpressure: holds in MEM with mem_req until mem_ready; flags mem_err once at MEM_TIMEOUT.
module mc_controller
  import mips_defs::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic       alu_zero,
  input  logic       mem_ready,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] npc_sel,
  output logic       reg_we,
  output logic [1:0] reg_dst,
  output logic [1:0] wd_sel,
  output logic       alu_src,
  output logic [1:0] ext_op,
  output logic [2:0] alu_ctrl,
  output logic       mem_req,
  output logic       mem_we,
  output logic       instr_done,
  output logic       illegal,
  output logic       mem_err
);

  // Wide enough to hold MEM_TIMEOUT itself so the count can saturate there
  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_SAT = CW'(MEM_TIMEOUT);
  localparam logic [CW-1:0] CNT_ERR = CW'(MEM_TIMEOUT - 1);

  logic [2:0]    state_q, state_d;
  logic [5:0]    op_q, func_q;
  logic [CW-1:0] wait_cnt;
  instr_t        ins;
  ctrl_t         ctrl;

  assign ins = classify(op_q, func_q);

  mc_decode u_decode (
    .state     (state_q),
    .op        (op_q),
    .func      (func_q),
    .alu_zero  (alu_zero),
    .mem_ready (mem_ready),
    .ctrl      (ctrl)
  );

  // Next-state sequencing; every path ends back in FETCH with no idle cycle
  always_comb begin
    state_d = ST_FETCH;
    case (state_q)
      ST_FETCH:  state_d = ST_DECODE;
      ST_DECODE: state_d = (ins == I_J || ins == I_JAL || ins == I_JR || ins == I_ILL)
                           ? ST_FETCH : ST_EXEC;
      ST_EXEC: begin
        case (ins)
          I_LW, I_SW:                    state_d = ST_MEM;
          I_ADDU, I_SUBU, I_ORI, I_LUI:  state_d = ST_WB;
          default:                       state_d = ST_FETCH;
        endcase
      end
      ST_MEM: begin
        if (!mem_ready)       state_d = ST_MEM;
        else if (ins == I_SW) state_d = ST_FETCH;
        else                  state_d = ST_WB;
      end
      ST_WB:   state_d = ST_FETCH;
      default: state_d = ST_FETCH;
    endcase
  end

  // State register plus op/func capture in FETCH
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_FETCH;
      op_q    <= '0;
      func_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_FETCH) begin
        op_q   <= op;
        func_q <= func;
      end
    end
  end

  // Count completed MEM wait cycles, saturating so the error fires only once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (state_q == ST_MEM && state_d == ST_MEM) begin
      if (wait_cnt != CNT_SAT) wait_cnt <= wait_cnt + CW'(1);
    end else begin
      wait_cnt <= '0;
    end
  end

  // Reset forces every output low immediately, independent of the clock
  assign ir_we      = !reset && ctrl.ir_we;
  assign pc_we      = !reset && ctrl.pc_we;
  assign instr_done = !reset && ctrl.pc_we;
  assign npc_sel    = reset ? 2'b00 : ctrl.npc_sel;
  assign reg_we     = !reset && ctrl.reg_we;
  assign reg_dst    = reset ? 2'b00 : ctrl.reg_dst;
  assign wd_sel     = reset ? 2'b00 : ctrl.wd_sel;
  assign alu_src    = !reset && ctrl.alu.alu_src;
  assign ext_op     = reset ? 2'b00 : ctrl.alu.ext_op;
  assign alu_ctrl   = reset ? 3'b000 : ctrl.alu.alu_ctrl;
  assign mem_req    = !reset && ctrl.mem_req;
  assign mem_we     = !reset && ctrl.mem_we;
  assign illegal    = !reset && ctrl.illegal;
  assign mem_err    = !reset && (state_q == ST_MEM) && (wait_cnt == CNT_ERR);

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: per-instruction expected output sequences.
// Latency: each instruction is driven one cycle per expected step.
// Backpressure: mem_ready is scheduled by the bench per instruction.
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op, func;
  logic       alu_zero, mem_ready;
  logic       ir_we, pc_we, reg_we, alu_src, mem_req, mem_we, instr_done, illegal, mem_err;
  logic [1:0] npc_sel, reg_dst, wd_sel, ext_op;
  logic [2:0] alu_ctrl;

  always #5 clk = ~clk;

  mc_controller #(.MEM_TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .op(op), .func(func), .alu_zero(alu_zero),
    .mem_ready(mem_ready), .ir_we(ir_we), .pc_we(pc_we), .npc_sel(npc_sel),
    .reg_we(reg_we), .reg_dst(reg_dst), .wd_sel(wd_sel), .alu_src(alu_src),
    .ext_op(ext_op), .alu_ctrl(alu_ctrl), .mem_req(mem_req), .mem_we(mem_we),
    .instr_done(instr_done), .illegal(illegal), .mem_err(mem_err)
  );

  typedef struct packed {
    logic       ir_we;
    logic       pc_we;
    logic [1:0] npc_sel;
    logic       reg_we;
    logic [1:0] reg_dst;
    logic [1:0] wd_sel;
    logic       alu_src;
    logic [1:0] ext_op;
    logic [2:0] alu_ctrl;
    logic       mem_req;
    logic       mem_we;
    logic       instr_done;
    logic       illegal;
    logic       mem_err;
  } ov_t;

  ov_t   got;
  assign got = {ir_we, pc_we, npc_sel, reg_we, reg_dst, wd_sel, alu_src, ext_op,
                alu_ctrl, mem_req, mem_we, instr_done, illegal, mem_err};

  int    n_cmp = 0;
  int    n_bad = 0;
  ov_t   seq[$];
  ov_t   exp_cur;
  logic  exp_valid = 1'b0;
  string cur_name = "reset";
  int    cur_step = 0;
  int    err_pulses;
  int    err_at;

  task automatic check(input string name, input logic [31:0] g, input logic [31:0] e);
    n_cmp++;
    if (g !== e) begin
      n_bad++;
      $display("FAIL %s [%s step %0d]: got %h expected %h", name, cur_name, cur_step, g, e);
    end
  endtask

  // Expected output sequence of one instruction, FETCH to retirement.
  // waits = MEM cycles with mem_ready low before the accepting cycle.
  task automatic build(input logic [5:0] o, input logic [5:0] f, input logic z, input int waits);
    ov_t w, a;
    bit  is_r, legal, is_ls, is_sw;
    seq.delete();
    w = '0; w.ir_we = 1'b1; seq.push_back(w);
    is_r  = (o == 6'h00);
    is_sw = (o == 6'h2b);
    is_ls = (o == 6'h23) || is_sw;
    if (o == 6'h02 || o == 6'h03 || (is_r && f == 6'h08)) begin
      w = '0; w.pc_we = 1'b1; w.instr_done = 1'b1;
      w.npc_sel = (is_r) ? 2'd3 : 2'd2;
      if (o == 6'h03) begin w.reg_we = 1'b1; w.reg_dst = 2'd2; w.wd_sel = 2'd2; end
      seq.push_back(w);
      return;
    end
    legal = (is_r && (f == 6'h21 || f == 6'h23)) || o == 6'h0d || o == 6'h0f ||
            is_ls || o == 6'h04;
    if (!legal) begin
      w = '0; w.illegal = 1'b1; w.pc_we = 1'b1; w.instr_done = 1'b1;
      seq.push_back(w);
      return;
    end
    seq.push_back('0);
    a = '0;
    if (is_r && f == 6'h23) a.alu_ctrl = 3'd1;
    if (o == 6'h0d) begin a.alu_src = 1'b1; a.alu_ctrl = 3'd2; end
    if (o == 6'h0f) begin a.alu_src = 1'b1; a.ext_op = 2'd2; a.alu_ctrl = 3'd3; end
    if (is_ls)      begin a.alu_src = 1'b1; a.ext_op = 2'd1; end
    if (o == 6'h04) begin
      w = a; w.alu_ctrl = 3'd1; w.pc_we = 1'b1; w.instr_done = 1'b1;
      w.npc_sel = z ? 2'd1 : 2'd0;
      seq.push_back(w);
      return;
    end
    seq.push_back(a);
    if (is_ls) begin
      for (int k = 0; k <= waits; k++) begin
        w = a; w.mem_req = 1'b1; w.mem_we = is_sw; w.mem_err = (k == 15);
        if (k == waits && is_sw) begin w.pc_we = 1'b1; w.instr_done = 1'b1; end
        seq.push_back(w);
      end
      if (is_sw) return;
    end
    w = a; w.reg_we = 1'b1; w.pc_we = 1'b1; w.instr_done = 1'b1;
    w.reg_dst = is_r ? 2'd1 : 2'd0;
    w.wd_sel  = (o == 6'h23) ? 2'd1 : 2'd0;
    seq.push_back(w);
  endtask

  // Drive one instruction; called just after an active edge with the DUT in FETCH.
  // abort_at >= 0 asserts reset mid-cycle at that step instead of completing.
  task automatic run_instr(input string name, input logic [5:0] o, input logic [5:0] f,
                           input logic z, input int waits, input int abort_at);
    bit is_ls;
    build(o, f, z, waits);
    is_ls = (o == 6'h23 || o == 6'h2b);
    cur_name = name;
    err_pulses = 0;
    err_at = -1;
    for (int i = 0; i < seq.size(); i++) begin
      cur_step  = i;
      op        = (i == 0) ? o : ~o;
      func      = (i == 0) ? f : ~f;
      alu_zero  = z;
      mem_ready = (is_ls && i >= 3) ? (i == 3 + waits) : 1'b1;
      exp_cur   = seq[i];
      exp_valid = 1'b1;
      #2;
      if (mem_err) begin err_pulses++; err_at = i - 2; end
      if (i == abort_at) begin
        exp_valid = 1'b0;
        reset = 1'b1;
        #1;
        check("async_reset_outputs", got, 32'd0);
        check("async_reset_mem_req", {31'd0, mem_req}, 32'd0);
        check("async_reset_mem_we", {31'd0, mem_we}, 32'd0);
        return;
      end
      @(posedge clk);
      #1;
    end
    exp_valid = 1'b0;
  endtask

  // Cycle-by-cycle comparison against the expected sequence plus global invariants
  always @(negedge clk) begin
    if (exp_valid) begin
      check("outputs", got, exp_cur);
      check("reg_we_and_mem_we", {31'd0, reg_we & mem_we}, 32'd0);
      check("done_eq_pc_we", {31'd0, instr_done}, {31'd0, pc_we});
    end
  end

  initial begin
    ov_t e;
    reset = 1'b1; op = '0; func = '0; alu_zero = 1'b0; mem_ready = 1'b0;

    // Pin the expectation model with hand-derived values
    build(6'h00, 6'h21, 1'b0, 0);
    check("model_addu_len", seq.size(), 32'd4);
    e = '0; e.reg_we = 1'b1; e.reg_dst = 2'd1; e.pc_we = 1'b1; e.instr_done = 1'b1;
    check("model_addu_wb", seq[3], e);
    build(6'h23, 6'h00, 1'b0, 3);
    check("model_lw3_len", seq.size(), 32'd8);
    build(6'h2b, 6'h00, 1'b0, 0);
    check("model_sw_len", seq.size(), 32'd4);
    build(6'h04, 6'h00, 1'b1, 0);
    check("model_beq_npc", {30'd0, seq[2].npc_sel}, 32'd1);
    build(6'h03, 6'h00, 1'b0, 0);
    check("model_jal_len", seq.size(), 32'd2);
    check("model_jal_dec", seq[1], 20'b0_1_10_1_10_10_0_00_000_0_0_1_0_0);

    // Reset held three cycles: everything low
    repeat (3) begin
      @(negedge clk);
      check("reset_hold", got, 32'd0);
    end
    @(posedge clk);
    #1 reset = 1'b0;

    run_instr("addu",  6'h00, 6'h21, 1'b0, 0, -1);
    run_instr("subu",  6'h00, 6'h23, 1'b0, 0, -1);
    run_instr("ori",   6'h0d, 6'h00, 1'b0, 0, -1);
    run_instr("lui",   6'h0f, 6'h00, 1'b0, 0, -1);
    run_instr("lw_w3", 6'h23, 6'h00, 1'b0, 3, -1);
    run_instr("lw_w0", 6'h23, 6'h00, 1'b0, 0, -1);
    run_instr("sw_w0", 6'h2b, 6'h00, 1'b0, 0, -1);
    run_instr("sw_w2", 6'h2b, 6'h00, 1'b0, 2, -1);
    run_instr("beq_t", 6'h04, 6'h00, 1'b1, 0, -1);
    run_instr("beq_f", 6'h04, 6'h00, 1'b0, 0, -1);
    run_instr("j",     6'h02, 6'h00, 1'b0, 0, -1);
    run_instr("jal",   6'h03, 6'h00, 1'b0, 0, -1);
    run_instr("jr",    6'h00, 6'h08, 1'b0, 0, -1);
    run_instr("ill3f", 6'h3f, 6'h00, 1'b0, 0, -1);
    run_instr("illrt", 6'h00, 6'h20, 1'b0, 0, -1);
    run_instr("addu2", 6'h00, 6'h21, 1'b0, 0, -1);

    // Store stalled past the timeout, then abandoned by reset in MEM cycle 18
    run_instr("sw_timeout", 6'h2b, 6'h00, 1'b0, 20, 20);
    check("mem_err_pulse_count", err_pulses, 32'd1);
    check("mem_err_mem_cycle", err_at, 32'd16);
    @(negedge clk);
    check("reset_mid_hold1", got, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("reset_mid_hold2", got, 32'd0);
    reset = 1'b0;
    #1;
    e = '0; e.ir_we = 1'b1;
    check("restart_fetch", got, e);
    run_instr("addu_after_reset", 6'h00, 6'h21, 1'b0, 0, -1);
    run_instr("lw_after_reset",   6'h23, 6'h00, 1'b0, 1, -1);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
